pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//  - Receive end of the duty-variator PWM link: measures an incoming PWM waveform and reports its duty in tenths (0..10) plus its period in clk cycles.
//  - Sits downstream of the PWM generator (loopback/self-test) or on an external PWM pin; all outputs are synchronous to clk.
// PARAMETERS
//  CNT_W           8   width of the period/high-time counters and period_out
//  TIMEOUT_CYCLES  64  cycles without a rising edge before the input is declared stuck (must be < 2**CNT_W)
//  SYNC_STAGES     2   flops in the pwm_in synchronizer (>=2)
//  DUTY_STEPS      10  duty resolution; duty_out range 0..DUTY_STEPS
// PORTS
//  clk             in   1      system clock (100 kHz nominal)
//  reset_n         in   1      asynchronous, active-low reset
//  pwm_in          in   1      PWM input, asynchronous to clk
//  duty_out        out  4      last decoded duty in tenths (0..10)
//  period_out      out  CNT_W  last measured period in clk cycles; 0 when stuck
//  duty_valid_out  out  1      one-cycle strobe: duty_out/period_out updated this cycle
//  stuck_out       out  1      1 = no rising edge within TIMEOUT_CYCLES (constant 0 %/100 % input)
// BEHAVIOUR
//  - Reset (async assert, sync deassert): duty_out=0, period_out=0, duty_valid_out=0, stuck_out=0, FSM=IDLE, counters=0, synchronizer=0, pipeline valid cleared.
//  - pwm_s = pwm_in after SYNC_STAGES flops; rise = pwm_s & ~pwm_s_d, fall = ~pwm_s & pwm_s_d. Both edges see equal latency, so widths are preserved.
//  - Counters: on rise, period_cnt<=1 and high_cnt<=1; otherwise period_cnt+=1 and high_cnt+=pwm_s, both saturating at 2**CNT_W-1.
//  - FSM states: IDLE, MEASURE, STUCK.
//    IDLE: first rise -> MEASURE, nothing emitted (partial period discarded).
//    MEASURE: rise -> capture P=period_cnt, H=high_cnt (pre-update values) into the quantizer; stay in MEASURE.
//    IDLE/MEASURE: period_cnt==TIMEOUT_CYCLES with no rise -> emit stuck result, go to STUCK.
//    STUCK: rise -> MEASURE (no emission); fall -> IDLE with period_cnt<=0, so a new timeout reports the new level.
//  - Rise and timeout in the same cycle: rise wins, no stuck emission.
//  - Quantizer, 2 stages: cycle R+1 registers N=H*DUTY_STEPS+(P>>1) and P.
//    cycle R+2 registers duty_out = number of k in 1..DUTY_STEPS with k*P <= N, i.e. round(H*10/P); also period_out=P, duty_valid_out=1, stuck_out=0.
//    Result latency is exactly 2 cycles after the rise cycle R. Back-to-back rises are fully pipelined, so the minimum period is 2 cycles.
//    N uses CNT_W+4 bits; k*P products use shift-add only, no divider.
//  - Stuck emission, registered the cycle after timeout: duty_out = pwm_s ? DUTY_STEPS : 0, period_out=0, stuck_out=1, duty_valid_out=1 for one cycle only.
//    stuck_out stays 1 until the next normal result.
//  - A stuck emission and a quantizer result never collide: the timeout needs TIMEOUT_CYCLES > 2 quiet cycles after the last rise.
//  - Reset mid-measurement discards the in-flight period and the pipeline; no strobe is produced.
//  - duty_out/period_out hold their value between strobes.
// STRUCTURE
//  - Shared pwm_pkg: DUTY_STEPS, DUTY_COUNT_MAX (=DUTY_STEPS-1), duty width (4), FSM state encoding.
//    The generator and this decoder import the same constants.
//  - Sub-module duty_quantizer: the 2-stage H/P -> tenths pipeline (inputs H, P, start; outputs duty, period, valid).
//    The synchronizer, edge detect, counters and FSM stay in the top.
// TESTING
//  1. Reset, then 10-cycle period with 3 high, repeated -> from the 2nd full period: duty_valid_out every 10 cycles, duty_out=3, period_out=10, stuck_out=0.
//  2. Sweep generator duty 1..9 (period 10) -> duty_out tracks 1..9 exactly; duty changes take effect on the first full period after the change.
//  3. pwm_in held high (duty 10) after a rise -> single strobe at 65 cycles after the rise (+sync latency): duty_out=10, period_out=0, stuck_out=1.
//     Then pwm_in falls and stays low -> second strobe after another 64 cycles: duty_out=0.
//  4. Period 7, high 2 -> duty_out=3 (2*10+3=23 >= 3*7). Period 4, high 1 -> duty_out=3 (10+2=12 >= 12).
//  5. reset_n low for 1 cycle mid-period, 1 cycle after a rise -> no strobe from the interrupted period; outputs at 0.
//     First result comes after two complete periods.
//  6. Rise arriving exactly at period_cnt==TIMEOUT_CYCLES -> no stuck strobe; normal result with period_out=64.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM link constants: duty resolution, widths and
// decoder FSM encoding used by both generator and decoder.
package pwm_pkg;

  localparam int DUTY_STEPS     = 10;
  localparam int DUTY_COUNT_MAX = DUTY_STEPS - 1;
  localparam int DUTY_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STUCK   = 2'd2
  } dec_state_e;

endpackage

// File: rtl/duty_quantizer.sv
// Two-stage H/P -> tenths pipeline: stage 1 forms the rounded
// numerator, stage 2 counts multiples of P that fit under it.
module duty_quantizer
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  high_cnt,
  input  logic [CNT_W-1:0]  period_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic [CNT_W-1:0]  period,
  output logic              valid
);

  localparam int NW = CNT_W + 4;

  logic [NW-1:0]     h_x;
  logic [NW-1:0]     n_next;
  logic [NW-1:0]     n_q;
  logic [CNT_W-1:0]  p_q;
  logic              v1_q;
  logic [NW-1:0]     acc;
  logic [DUTY_W-1:0] k_cnt;

  // H*10 as (H<<3)+(H<<1); P>>1 makes the count round to nearest
  assign h_x    = NW'(high_cnt);
  assign n_next = (h_x << 3) + (h_x << 1) + NW'(period_cnt >> 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q  <= '0;
      p_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= start;
      if (start) begin
        n_q <= n_next;
        p_q <= period_cnt;
      end
    end
  end

  always_comb begin
    acc   = '0;
    k_cnt = '0;
    for (int k = 0; k <= DUTY_COUNT_MAX; k++) begin
      acc = acc + NW'(p_q);
      if (acc <= n_q) k_cnt = k_cnt + DUTY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty   <= '0;
      period <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= v1_q;
      if (v1_q) begin
        duty   <= k_cnt;
        period <= p_q;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receive end: synchronizes pwm_in, measures period/high time
// between rising edges and reports duty in tenths or a stuck level.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  period_out,
  output logic              duty_valid_out,
  output logic              stuck_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_s_d;
  logic                   rise;
  logic                   fall;
  logic                   timeout;
  logic [CNT_W-1:0]       period_cnt;
  logic [CNT_W-1:0]       high_cnt;
  dec_state_e             state_q;
  dec_state_e             state_d;
  logic                   start;
  logic                   stuck_fire;
  logic                   clr_period;
  logic                   stuck_q;
  logic                   stuck_lvl_q;
  logic                   stuck_strobe_q;
  logic [DUTY_W-1:0]      q_duty;
  logic [CNT_W-1:0]       q_period;
  logic                   q_valid;

  assign pwm_s   = sync_q[SYNC_STAGES-1];
  assign rise    = pwm_s & ~pwm_s_d;
  assign fall    = ~pwm_s & pwm_s_d;
  assign timeout = (period_cnt == TMO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      pwm_s_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_s_d <= pwm_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else begin
      if (clr_period)
        period_cnt <= '0;
      else if (period_cnt != CNT_MAX)
        period_cnt <= period_cnt + CNT_W'(1);
      if (pwm_s && high_cnt != CNT_MAX)
        high_cnt <= high_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // rise has priority over a coincident timeout
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    stuck_fire = 1'b0;
    clr_period = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (timeout) begin
          stuck_fire = 1'b1;
          state_d    = ST_STUCK;
        end
      end
      ST_MEASURE: begin
        if (rise) begin
          start = 1'b1;
        end else if (timeout) begin
          stuck_fire = 1'b1;
          state_d    = ST_STUCK;
        end
      end
      ST_STUCK: begin
        if (rise) begin
          state_d = ST_MEASURE;
        end else if (fall) begin
          clr_period = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  duty_quantizer #(
    .CNT_W(CNT_W)
  ) u_quant (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .duty      (q_duty),
    .period    (q_period),
    .valid     (q_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stuck_q        <= 1'b0;
      stuck_lvl_q    <= 1'b0;
      stuck_strobe_q <= 1'b0;
    end else begin
      stuck_strobe_q <= stuck_fire;
      if (stuck_fire) begin
        stuck_q     <= 1'b1;
        stuck_lvl_q <= pwm_s;
      end else if (q_valid) begin
        stuck_q <= 1'b0;
      end
    end
  end

  // a fresh quantizer result overrides a held stuck report
  assign stuck_out      = stuck_q & ~q_valid;
  assign duty_out       = stuck_out ?
                          (stuck_lvl_q ? DUTY_W'(DUTY_STEPS) : '0) :
                          q_duty;
  assign period_out     = stuck_out ? '0 : q_period;
  assign duty_valid_out = q_valid | stuck_strobe_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: directed PWM patterns,
// expected strobes queued by the driver, checked by a monitor.
module tb_pwm_duty_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [3:0] duty_out;
  logic [7:0] period_out;
  logic       duty_valid_out;
  logic       stuck_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int d;
    int p;
    int s;
    int t;
  } exp_t;

  exp_t sb[$];
  bit   meas = 1'b0;
  int   prev_p = 0;
  int   prev_d = 0;

  pwm_duty_decoder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pwm_in        (pwm_in),
    .duty_out      (duty_out),
    .period_out    (period_out),
    .duty_valid_out(duty_valid_out),
    .stuck_out     (stuck_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n && duty_valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("duty", int'(duty_out), e.d);
        check("period", int'(period_out), e.p);
        check("stuck", int'(stuck_out), e.s);
        check("strobe_cycle", cyc, e.t);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    meas    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_duty", int'(duty_out), 0);
    check("rst_period", int'(period_out), 0);
    check("rst_valid", int'(duty_valid_out), 0);
    check("rst_stuck", int'(stuck_out), 0);
    reset_n = 1'b1;
  endtask

  // result of the previous period appears 4 cycles after this drive
  task automatic rise_edge();
    @(negedge clk);
    pwm_in = 1'b1;
    if (meas) sb.push_back('{prev_d, prev_p, 0, cyc + 4});
    meas = 1'b1;
  endtask

  task automatic run(int p, int h, int d);
    rise_edge();
    for (int i = 1; i < p; i++) begin
      @(negedge clk);
      pwm_in = (i < h);
    end
    prev_p = p;
    prev_d = d;
  endtask

  task automatic close_stream();
    rise_edge();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: steady 3/10
    do_reset();
    for (int i = 0; i < 5; i++) run(10, 3, 3);
    close_stream();
    repeat (10) @(negedge clk);
    check("hold_duty", int'(duty_out), 3);
    check("hold_period", int'(period_out), 10);

    // 2: sweep 1..9
    do_reset();
    for (int h = 1; h <= 9; h++) run(10, h, h);
    close_stream();

    // 3: stuck high, then stuck low, then recovery
    do_reset();
    repeat (3) @(negedge clk);
    rise_edge();
    sb.push_back('{10, 0, 1, cyc + 67});
    repeat (80) @(negedge clk);
    check("stuck_hold_hi", int'(stuck_out), 1);
    check("stuck_duty_hi", int'(duty_out), 10);
    @(negedge clk);
    pwm_in = 1'b0;
    sb.push_back('{0, 0, 1, cyc + 68});
    meas = 1'b0;
    repeat (80) @(negedge clk);
    check("stuck_hold_lo", int'(stuck_out), 1);
    check("stuck_duty_lo", int'(duty_out), 0);
    check("stuck_period_lo", int'(period_out), 0);
    run(10, 4, 4);
    run(10, 4, 4);
    close_stream();
    check("stuck_cleared", int'(stuck_out), 0);

    // 4: rounding boundaries
    do_reset();
    run(7, 2, 3);
    run(7, 2, 3);
    run(4, 1, 3);
    run(4, 1, 3);
    close_stream();

    // 5: reset pulse one cycle after a rise
    do_reset();
    repeat (2) @(negedge clk);
    rise_edge();
    @(negedge clk);
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    meas    = 1'b0;
    check("midrst_duty", int'(duty_out), 0);
    check("midrst_period", int'(period_out), 0);
    check("midrst_stuck", int'(stuck_out), 0);
    repeat (8) @(negedge clk);
    run(10, 1, 1);
    run(10, 1, 1);
    close_stream();

    // 6: rise coincides with timeout count
    do_reset();
    run(10, 3, 3);
    run(64, 20, 3);
    run(10, 5, 5);
    close_stream();

    repeat (10) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
